// File: rtl/alu_cmd_initiator.sv
// alu_cmd_initiator: initiator for a combinational sel/op/data1/data2 -> 16-bit ALU.
// Accepts one command at a time and drives it onto the ALU for SETTLE_CYCLES.
// It then samples the ALU result into a first-word-fall-through response FIFO.
// A divide by zero is answered locally with {16'hFFFF, err=1}; it never reaches the ALU.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   cmd_valid/cmd_ready           command stream handshake
//   cmd_sel/op/data1/data2        command payload
//   alu_sel/op/data1/data2        held ALU inputs
//   alu_result                    ALU output
//   rsp_valid/rsp_ready           response stream handshake
//   rsp_data, rsp_err             FIFO head entry
//   busy                          command in flight
module alu_cmd_initiator #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_sel,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_data1,
  input  logic [7:0]  cmd_data2,
  output logic        alu_sel,
  output logic [1:0]  alu_op,
  output logic [7:0]  alu_data1,
  output logic [7:0]  alu_data2,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SET_W = 4;
  localparam int unsigned ENT_W = 17;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_TRAP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];

  logic             accept_c;
  logic             div0_c;
  logic             load_alu_c;
  logic             push_c;
  logic             pop_c;
  logic [ENT_W-1:0] push_ent_c;
  logic             ready_d;

  assign accept_c = cmd_valid && cmd_ready;
  assign div0_c   = !cmd_sel && (cmd_op == 2'd3) && (cmd_data2 == 8'd0);
  assign pop_c    = rsp_valid && rsp_ready;

  // Next-state, settle counter and FIFO push decode.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    load_alu_c = 1'b0;
    push_c     = 1'b0;
    push_ent_c = '0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (div0_c) begin
            state_d = S_TRAP;
          end else begin
            load_alu_c = 1'b1;
            settle_d   = SET_W'(SETTLE_CYCLES - 1);
            state_d    = S_DRIVE;
          end
        end
      end
      S_DRIVE: begin
        if (settle_q == '0) begin
          push_c     = 1'b1;
          push_ent_c = {1'b0, alu_result};
          state_d    = S_IDLE;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      S_TRAP: begin
        push_c     = 1'b1;
        push_ent_c = {1'b1, 16'hFFFF};
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
  // Space is reserved at accept time, so an in-flight push always fits.
  assign ready_d = (state_d == S_IDLE) && (count_d < CNT_W'(FIFO_DEPTH));

  // Control state and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      settle_q  <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      count_q   <= count_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cmd_ready <= ready_d;
      rsp_valid <= (count_d != '0);
      busy      <= (state_d != S_IDLE);
    end
  end

  // ALU inputs hold the last non-trapped command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_sel   <= 1'b0;
      alu_op    <= 2'd0;
      alu_data1 <= 8'd0;
      alu_data2 <= 8'd0;
    end else if (load_alu_c) begin
      alu_sel   <= cmd_sel;
      alu_op    <= cmd_op;
      alu_data1 <= cmd_data1;
      alu_data2 <= cmd_data2;
    end
  end

  // Response storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push_c) begin
      mem_q[wr_ptr_q] <= push_ent_c;
    end
  end

  assign rsp_data = mem_q[rd_ptr_q][15:0];
  assign rsp_err  = mem_q[rd_ptr_q][16];

endmodule

// File: tb/tb_alu_cmd_initiator.sv
module tb_alu_cmd_initiator;

  localparam int unsigned SETTLE = 3;
  localparam int unsigned DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_sel;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data1, cmd_data2;
  logic        alu_sel;
  logic [1:0]  alu_op;
  logic [7:0]  alu_data1, alu_data2;
  logic [15:0] alu_result;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [15:0] rsp_data;

  int total = 0;
  int bad   = 0;
  int rdy_mode = 0;  // 0 never, 1 always, 2 random, 3 manual
  logic [16:0] exp_q[$];
  logic [18:0] last_alu = '0;

  always #5 clk = ~clk;

  alu_cmd_initiator #(.SETTLE_CYCLES(SETTLE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel), .cmd_op(cmd_op),
    .cmd_data1(cmd_data1), .cmd_data2(cmd_data2),
    .alu_sel(alu_sel), .alu_op(alu_op), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Arithmetic/logic unit semantics, input vector {sel, op, d1, d2}.
  function automatic logic [15:0] alu_fn(input logic [18:0] v);
    logic [7:0] a, b;
    a = v[15:8];
    b = v[7:0];
    case ({v[18], v[17:16]})
      3'b000: return 16'(a) + 16'(b);
      3'b001: return 16'(a) - 16'(b);
      3'b010: return 16'(a) * 16'(b);
      3'b011: return (b == 8'd0) ? 16'hFFFF : 16'(a / b);
      3'b100: return {8'h00, ~(a & b)};
      3'b101: return {8'h00, ~(a | b)};
      3'b110: return {8'h00, ~a};
      default: return {8'h00, a ^ b};
    endcase
  endfunction

  // Expected response {err, data} for one command.
  function automatic logic [16:0] ref_rsp(input logic s, input logic [1:0] o,
                                          input logic [7:0] a, input logic [7:0] b);
    if (!s && o == 2'd3 && b == 8'd0) return {1'b1, 16'hFFFF};
    return {1'b0, alu_fn({s, o, a, b})};
  endfunction

  // ALU model: result is garbage until its inputs have been stable for SETTLE edges.
  logic [18:0] alu_cur, alu_last;
  int          age = 0;
  int          held;
  assign alu_cur = {alu_sel, alu_op, alu_data1, alu_data2};
  always @(posedge clk) begin
    if (alu_cur !== alu_last) begin
      alu_last <= alu_cur;
      age <= 1;
    end else if (age < 100) begin
      age <= age + 1;
    end
  end
  always_comb begin
    held = (alu_cur !== alu_last) ? 1 : age + 1;
    alu_result = (held >= int'(SETTLE)) ? alu_fn(alu_cur) : 16'hDEAD;
  end

  // Response ready generator, changes just after the rising edge.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: rsp_ready = 1'b0;
        1: rsp_ready = 1'b1;
        2: rsp_ready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  // Scoreboard monitor.
  logic [16:0] m_e;
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_data), 32'hFFFF_FFFF);
      end else begin
        m_e = exp_q.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(m_e[15:0]));
        chk("rsp_err", 32'(rsp_err), 32'(m_e[16]));
      end
    end
  end

  // Issue one command; caller is at a falling edge. Checks hold/busy timing inline.
  task automatic send(input logic s, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [16:0] e;
    int budget;
    int lat;
    cmd_valid = 1'b1; cmd_sel = s; cmd_op = o; cmd_data1 = a; cmd_data2 = b;
    budget = 0;
    while (!cmd_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e = ref_rsp(s, o, a, b);
    exp_q.push_back(e);
    if (!e[16]) last_alu = {s, o, a, b};
    lat = e[16] ? 1 : int'(SETTLE);
    @(negedge clk);
    // Garbage while not ready must be ignored.
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_sel = 1'($urandom); cmd_op = 2'($urandom); cmd_data1 = 8'($urandom); cmd_data2 = 8'($urandom);
    for (int k = 1; k <= lat; k++) begin
      chk("busy_hold", 32'(busy), 32'd1);
      chk("ready_hold", 32'(cmd_ready), 32'd0);
      chk("alu_hold", 32'(alu_cur), 32'(last_alu));
      @(negedge clk);
    end
    chk("busy_done", 32'(busy), 32'd0);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    rdy_mode = 1;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_sel = 1'b0; cmd_op = 2'd0; cmd_data1 = 8'd0; cmd_data2 = 8'd0;
    #3;
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu", 32'(alu_cur), 32'd0);
    chk("rst_rsp_data", 32'({rsp_err, rsp_data}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Directed basics.
    rdy_mode = 1;
    send(1'b0, 2'd0, 8'd200, 8'd100);
    send(1'b0, 2'd2, 8'hFF, 8'hFF);
    send(1'b0, 2'd3, 8'd10, 8'd0);
    send(1'b0, 2'd3, 8'd100, 8'd7);
    drain();

    // FIFO full: four queued, fifth waits until one pop.
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    send(1'b1, 2'd0, 8'h12, 8'h34);
    send(1'b0, 2'd1, 8'd5, 8'd9);
    send(1'b0, 2'd3, 8'd1, 8'd0);
    send(1'b1, 2'd2, 8'h3C, 8'h00);
    fork
      send(1'b1, 2'd1, 8'h0F, 8'hF0);
      begin
        repeat (3) begin
          chk("full_ready", 32'(cmd_ready), 32'd0);
          chk("full_valid", 32'(rsp_valid), 32'd1);
          @(negedge clk);
        end
        rdy_mode = 1;
      end
    join
    drain();

    // Push and pop on the same edge with one entry stored.
    rdy_mode = 3;
    rsp_ready = 1'b0;
    send(1'b0, 2'd0, 8'd1, 8'd2);
    fork
      send(1'b1, 2'd3, 8'hA5, 8'h0F);
      begin : same_edge
        int w;
        w = 0;
        while (w < 50) begin
          @(posedge clk);
          if (cmd_valid && cmd_ready) break;
          w++;
        end
        if (w >= 50) chk("same_edge_timeout", 32'd0, 32'd1);
        repeat (SETTLE - 1) @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("same_edge_valid", 32'(rsp_valid), 32'd1);
        chk("same_edge_head", 32'(rsp_data), 32'h00AA);
      end
    join
    drain();

    // Reset in the middle of a command: nothing is produced afterwards.
    cmd_valid = 1'b1; cmd_sel = 1'b0; cmd_op = 2'd2; cmd_data1 = 8'd7; cmd_data2 = 8'd9;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_alu", 32'(alu_cur), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
    last_alu = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_valid", 32'(rsp_valid), 32'd0);

    // Randomized traffic with random backpressure.
    rdy_mode = 2;
    for (int n = 0; n < 150; n++) begin
      logic        s;
      logic [1:0]  o;
      logic [7:0]  a, b;
      s = 1'($urandom);
      o = 2'($urandom);
      a = 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(s, o, a, b);
    end
    drain();
    chk("final_empty", 32'(rsp_valid), 32'd0);
    chk("final_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
